// File: rtl/pipeline_ctrl.sv
// Stall/flush sequencer for the IF/ID/EX/MEM/WB pipeline: per-stage ready_go and
// flush, PC redirect selection, multi-cycle unit handshake and a stall-cycle counter.
module pipeline_ctrl #(
  parameter int REG_W     = 5,
  parameter int FLUSH_CYC = 1,
  parameter int CNT_W     = 32
) (
  input  logic             aclk,
  input  logic             aresetn,
  input  logic [4:0]       stage_valid,
  input  logic             if_inst_ok,
  input  logic [REG_W-1:0] id_rj,
  input  logic [REG_W-1:0] id_rk,
  input  logic             id_rj_used,
  input  logic             id_rk_used,
  input  logic             ex_is_load,
  input  logic [REG_W-1:0] ex_rd,
  input  logic             ex_mc_req,
  input  logic             mc_done,
  input  logic             ex_br_taken,
  input  logic             mem_wait,
  input  logic             mem_data_ok,
  input  logic             wb_exc,
  input  logic             wb_ertn,
  output logic [4:0]       ready_go,
  output logic [4:0]       flush,
  output logic             redirect,
  output logic [1:0]       redirect_src,
  output logic             mc_start,
  output logic             mc_abort,
  output logic [1:0]       ctrl_state,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam logic [1:0] ST_RUN     = 2'b00;
  localparam logic [1:0] ST_MC_WAIT = 2'b01;
  localparam logic [1:0] ST_DRAIN   = 2'b10;

  localparam int DCW = (FLUSH_CYC < 2) ? 1 : $clog2(FLUSH_CYC + 1);
  localparam logic [DCW-1:0] DRAIN_LOAD = DCW'(FLUSH_CYC);
  localparam logic [DCW-1:0] DRAIN_ONE  = DCW'(1);

  logic [1:0]       state_q, state_d;
  logic [DCW-1:0]   drain_q, drain_d;
  logic [CNT_W-1:0] stall_q, stall_d;

  logic       loaduse, exc_evt, br_evt, mc_req_run, mc_start_w, stall_hit;
  logic [4:0] rg_w;

  always_comb begin
    loaduse = stage_valid[2] & ex_is_load & (ex_rd != '0) & stage_valid[1] &
              ((id_rj_used & (id_rj == ex_rd)) | (id_rk_used & (id_rk == ex_rd)));
    mc_req_run = (state_q == ST_RUN) & stage_valid[2] & ex_mc_req;

    rg_w[0] = if_inst_ok;
    rg_w[1] = ~loaduse;
    rg_w[2] = ~((state_q == ST_MC_WAIT) & ~mc_done) & ~mc_req_run;
    rg_w[3] = ~(mem_wait & ~mem_data_ok);
    rg_w[4] = 1'b1;

    exc_evt    = stage_valid[4] & (wb_exc | wb_ertn);
    br_evt     = stage_valid[2] & ex_br_taken & rg_w[2] & ~exc_evt;
    mc_start_w = mc_req_run & ~exc_evt;
    stall_hit  = |(stage_valid[3:0] & ~rg_w[3:0]);
  end

  // Event outputs are purely combinational; reset forces the quiescent/flush-all pattern.
  always_comb begin
    ready_go     = rg_w;
    flush        = 5'b00000;
    redirect     = 1'b0;
    redirect_src = 2'b00;
    mc_start     = mc_start_w;
    mc_abort     = exc_evt & ((state_q == ST_MC_WAIT) | mc_start_w);
    if (exc_evt) begin
      flush        = 5'b01111;
      redirect     = 1'b1;
      redirect_src = wb_exc ? 2'b10 : 2'b11;
    end else if (br_evt) begin
      flush        = 5'b00011;
      redirect     = 1'b1;
      redirect_src = 2'b01;
    end
    if (state_q == ST_DRAIN) flush[0] = 1'b1;
    if (!aresetn) begin
      ready_go     = 5'b00000;
      flush        = 5'b11111;
      redirect     = 1'b0;
      redirect_src = 2'b00;
      mc_start     = 1'b0;
      mc_abort     = 1'b0;
    end
  end

  always_comb begin
    state_d = state_q;
    drain_d = drain_q;
    stall_d = (stall_hit && (stall_q != '1)) ? stall_q + 1'b1 : stall_q;
    if (exc_evt) begin
      state_d = ST_DRAIN;
      drain_d = DRAIN_LOAD;
    end else begin
      case (state_q)
        ST_RUN:     if (mc_start_w) state_d = ST_MC_WAIT;
        ST_MC_WAIT: if (mc_done) state_d = ST_RUN;
        ST_DRAIN: begin
          if (drain_q == DRAIN_ONE) begin
            state_d = ST_RUN;
            drain_d = '0;
          end else begin
            drain_d = drain_q - DRAIN_ONE;
          end
        end
        default:    state_d = ST_RUN;
      endcase
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q <= ST_RUN;
      drain_q <= '0;
      stall_q <= '0;
    end else begin
      state_q <= state_d;
      drain_q <= drain_d;
      stall_q <= stall_d;
    end
  end

  assign ctrl_state = state_q;
  assign stall_cnt  = stall_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl: load-use, div handshake, branch, exception
// drain, event priority, async reset and counter saturation (CNT_W=4, FLUSH_CYC=2).
module tb_pipeline_ctrl;

  logic       aclk, aresetn;
  logic [4:0] stage_valid;
  logic       if_inst_ok, id_rj_used, id_rk_used, ex_is_load, ex_mc_req, mc_done;
  logic       ex_br_taken, mem_wait, mem_data_ok, wb_exc, wb_ertn;
  logic [4:0] id_rj, id_rk, ex_rd;
  logic [4:0] ready_go, flush;
  logic       redirect, mc_start, mc_abort;
  logic [1:0] redirect_src, ctrl_state;
  logic [3:0] stall_cnt;

  int total = 0;
  int bad   = 0;

  pipeline_ctrl #(.REG_W(5), .FLUSH_CYC(2), .CNT_W(4)) dut (
    .aclk(aclk), .aresetn(aresetn), .stage_valid(stage_valid), .if_inst_ok(if_inst_ok),
    .id_rj(id_rj), .id_rk(id_rk), .id_rj_used(id_rj_used), .id_rk_used(id_rk_used),
    .ex_is_load(ex_is_load), .ex_rd(ex_rd), .ex_mc_req(ex_mc_req), .mc_done(mc_done),
    .ex_br_taken(ex_br_taken), .mem_wait(mem_wait), .mem_data_ok(mem_data_ok),
    .wb_exc(wb_exc), .wb_ertn(wb_ertn), .ready_go(ready_go), .flush(flush),
    .redirect(redirect), .redirect_src(redirect_src), .mc_start(mc_start),
    .mc_abort(mc_abort), .ctrl_state(ctrl_state), .stall_cnt(stall_cnt)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end else begin
      $display("ok   %s = %0h", tag, got);
    end
  endtask

  task automatic clr();
    stage_valid = '0; if_inst_ok = 0; id_rj = '0; id_rk = '0; id_rj_used = 0; id_rk_used = 0;
    ex_is_load = 0; ex_rd = '0; ex_mc_req = 0; mc_done = 0; ex_br_taken = 0;
    mem_wait = 0; mem_data_ok = 0; wb_exc = 0; wb_ertn = 0;
  endtask

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic do_reset();
    clr();
    aresetn = 0;
    #2;
    aresetn = 1;
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

  initial begin
    clr();
    aresetn = 0;
    stage_valid = 5'b00100; ex_mc_req = 1; if_inst_ok = 1;
    #3;
    chk("rst_rg", ready_go, 5'b00000);
    chk("rst_flush", flush, 5'b11111);
    chk("rst_redir", redirect, 0);
    chk("rst_src", redirect_src, 0);
    chk("rst_mcstart", mc_start, 0);
    chk("rst_state", ctrl_state, 0);
    chk("rst_cnt", stall_cnt, 0);
    clr();
    @(negedge aclk) aresetn = 1;
    tick();

    // load-use on rj, then ex_rd=0, then rk match with/without rk_used
    if_inst_ok = 1; stage_valid = 5'b00110; ex_is_load = 1; ex_rd = 5;
    id_rj = 5; id_rj_used = 1; id_rk = 1; id_rk_used = 1; #1;
    chk("lu_rg", ready_go, 5'b11101);
    tick();
    chk("lu_cnt", stall_cnt, 1);
    ex_rd = 0; id_rj = 0; #1;
    chk("lu_r0_rg", ready_go, 5'b11111);
    tick();
    chk("lu_r0_cnt", stall_cnt, 1);
    ex_rd = 7; id_rj = 3; id_rk = 7; #1;
    chk("lu_rk_rg", ready_go, 5'b11101);
    id_rk_used = 0; #1;
    chk("lu_rk_unused", ready_go, 5'b11111);
    tick();
    chk("lu_rk_cnt", stall_cnt, 1);

    // div: start cycle plus 8 waiting cycles stall, done on the 9th wait cycle
    do_reset();
    stage_valid = 5'b00100; ex_mc_req = 1; if_inst_ok = 1; #1;
    chk("div_start", mc_start, 1);
    chk("div_rg", ready_go, 5'b11011);
    chk("div_state0", ctrl_state, 0);
    tick();
    chk("div_state1", ctrl_state, 1);
    chk("div_start_off", mc_start, 0);
    ex_br_taken = 1; #1;
    chk("div_br_flush", flush, 0);
    chk("div_br_redir", redirect, 0);
    ex_br_taken = 0;
    repeat (8) tick();
    mc_done = 1; #1;
    chk("div_done_rg", ready_go, 5'b11111);
    chk("div_cnt", stall_cnt, 9);
    tick();
    clr();
    if_inst_ok = 1; #1;
    chk("div_run", ctrl_state, 0);
    chk("div_cnt_hold", stall_cnt, 9);

    // branch redirect in RUN
    stage_valid = 5'b00100; ex_br_taken = 1; #1;
    chk("br_flush", flush, 5'b00011);
    chk("br_redir", redirect, 1);
    chk("br_src", redirect_src, 2'b01);
    stage_valid = 5'b00000; #1;
    chk("br_novalid", redirect, 0);
    clr(); tick();

    // exception while div waits, then DRAIN of two cycles ignoring mc_done
    stage_valid = 5'b00100; ex_mc_req = 1; if_inst_ok = 1;
    tick();
    chk("exc_mcwait", ctrl_state, 1);
    stage_valid = 5'b10100; wb_exc = 1; #1;
    chk("exc_flush", flush, 5'b01111);
    chk("exc_src", redirect_src, 2'b10);
    chk("exc_abort", mc_abort, 1);
    chk("exc_redir", redirect, 1);
    tick();
    clr(); if_inst_ok = 1; mc_done = 1; #1;
    chk("drn_state", ctrl_state, 2);
    chk("drn_flush", flush, 5'b00001);
    chk("drn_abort", mc_abort, 0);
    tick();
    chk("drn_state2", ctrl_state, 2);
    tick();
    chk("drn_end", ctrl_state, 0);
    chk("drn_end_flush", flush, 0);
    clr(); tick();

    // priority: exception beats ertn and branch; ertn alone; reload in DRAIN
    stage_valid = 5'b11100; wb_exc = 1; wb_ertn = 1; ex_br_taken = 1; #1;
    chk("pri_src", redirect_src, 2'b10);
    chk("pri_flush", flush, 5'b01111);
    wb_exc = 0; #1;
    chk("ertn_src", redirect_src, 2'b11);
    tick();
    clr(); stage_valid = 5'b10000; wb_ertn = 1; #1;
    chk("reload_flush", flush, 5'b01111);
    tick();
    clr(); tick();
    chk("reload_state", ctrl_state, 2);
    tick();
    chk("reload_end", ctrl_state, 0);

    // memory wait stalls MEM only until data returns
    stage_valid = 5'b01000; mem_wait = 1; if_inst_ok = 1; #1;
    chk("mem_wait_rg", ready_go, 5'b10111);
    mem_data_ok = 1; #1;
    chk("mem_ok_rg", ready_go, 5'b11111);
    clr(); tick();

    // async reset while waiting on div
    stage_valid = 5'b00100; ex_mc_req = 1; if_inst_ok = 1;
    tick();
    chk("ar_mcwait", ctrl_state, 1);
    aresetn = 0; #1;
    chk("ar_rg", ready_go, 0);
    chk("ar_flush", flush, 5'b11111);
    chk("ar_state", ctrl_state, 0);
    chk("ar_cnt", stall_cnt, 0);
    clr(); #2;
    aresetn = 1;
    tick();
    chk("ar_run", ctrl_state, 0);

    // saturation of the 4-bit counter with IF stalled
    stage_valid = 5'b00001; if_inst_ok = 0;
    repeat (14) tick();
    chk("sat_14", stall_cnt, 14);
    tick();
    chk("sat_15", stall_cnt, 15);
    repeat (5) tick();
    chk("sat_hold", stall_cnt, 15);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
